// File: rtl/d_to_jk_driver_if.sv
// Signal bundle between a D-style word producer, the d_to_jk_driver and an external JK bank.
// The master side offers words and the bank state; the slave side is the driver.
interface d_to_jk_driver_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             jk_strobe;
    logic             busy;
    logic             done;
    logic [ERR_W-1:0] err_cnt;
    logic             err_flag;

    modport master (
        output in_valid, in_data, q_fb,
        input  in_ready, j, k, jk_strobe, busy, done, err_cnt, err_flag
    );

    modport slave (
        input  in_valid, in_data, q_fb,
        output in_ready, j, k, jk_strobe, busy, done, err_cnt, err_flag
    );
endinterface

// File: rtl/d_to_jk_driver.sv
// Converts D-style target words into one strobed cycle of minimal J/K excitation for an external JK bank.
// Optional read-back checking with a saturating mismatch counter is enabled by defining JK_CHECK_EN.
module d_to_jk_driver #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    d_to_jk_driver_if.slave   bus
);

`ifdef JK_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SETTLE = 2'd2,
        S_CHECK  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;
`endif

    state_t           r_state;
    state_t           w_next;
    logic             w_ready;
    logic             w_accept;
    logic             w_strobe;
    logic             w_done;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;

    assign w_ready  = (r_state == S_IDLE) && rst_n;
    assign w_accept = w_ready && bus.in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_strobe = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_APPLY;
                end
            end
            S_APPLY: begin
                w_strobe = 1'b1;
                w_next   = S_SETTLE;
            end
            S_SETTLE: begin
`ifdef JK_CHECK_EN
                w_next = S_CHECK;
`else
                w_done = 1'b1;
                w_next = S_IDLE;
`endif
            end
`ifdef JK_CHECK_EN
            S_CHECK: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Don't-cares resolved to 0 so a bit is never toggled: j&k is always 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_j <= '0;
            r_k <= '0;
        end else if (w_accept) begin
            r_j <= bus.in_data & ~bus.q_fb;
            r_k <= ~bus.in_data & bus.q_fb;
        end
    end

    // Gating by rst_n keeps an asserted reset from clocking the bank mid-transaction.
    assign bus.in_ready  = w_ready;
    assign bus.jk_strobe = w_strobe && rst_n;
    assign bus.j         = r_j & {WIDTH{w_strobe && rst_n}};
    assign bus.k         = r_k & {WIDTH{w_strobe && rst_n}};
    assign bus.done      = w_done && rst_n;
    assign bus.busy      = (r_state != S_IDLE);

`ifdef JK_CHECK_EN
    logic [WIDTH-1:0] r_tgt;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_err_flag;
    logic             w_mismatch;

    assign w_mismatch = (r_state == S_CHECK) && (bus.q_fb != r_tgt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tgt <= '0;
        end else if (w_accept) begin
            r_tgt <= bus.in_data;
        end
    end

    // One count per failing transaction, not per bit; holds at all ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
        end else if (w_mismatch) begin
            r_err_flag <= 1'b1;
            if (r_err_cnt != {ERR_W{1'b1}}) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign bus.err_cnt  = r_err_cnt;
    assign bus.err_flag = r_err_flag;
`else
    assign bus.err_cnt  = '0;
    assign bus.err_flag = 1'b0;
`endif

endmodule
